// File: rtl/move_sort_topk_pkg.sv
// move_sort_topk_pkg -- shared constants, entry flag offsets and sorter state encoding.
// Rev 1.0
`default_nettype none
package move_sort_topk_pkg;

  localparam int MAX_POSITIONS_LOG2_DEF = 8;
  localparam int MAX_POSITIONS          = 1 << MAX_POSITIONS_LOG2_DEF;

  // Flag bits sit directly above the eval field: entry[EVAL_WIDTH + OFS].
  localparam int BLACK_IN_CHECK_OFS = 0;
  localparam int WHITE_IN_CHECK_OFS = 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PASS_INIT  = 3'd1,
    S_READ_WS    = 3'd2,
    S_COMPARE    = 3'd3,
    S_SWAP       = 3'd4,
    S_STEP       = 3'd5,
    S_PASS_CHECK = 3'd6,
    S_DONE       = 3'd7
  } sort_state_t;

endpackage
`default_nettype wire

// File: rtl/move_sort_topk_if.sv
// move_sort_topk_if -- host-side control, status and RAM access signals of the move sorter.
// Rev 1.0
`default_nettype none
interface move_sort_topk_if
  import move_sort_topk_pkg::*;
#(
  parameter int RAM_WIDTH          = 64,
  parameter int MAX_POSITIONS_LOG2 = MAX_POSITIONS_LOG2_DEF
);
  logic                          sort_start;
  logic                          sort_clear;
  logic                          white_to_move;
  logic [MAX_POSITIONS_LOG2-1:0] top_k;
  logic                          ram_wr_addr_init;
  logic                          ram_wr;
  logic [RAM_WIDTH-1:0]          ram_wr_data;
  logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr;
  logic [RAM_WIDTH-1:0]          ram_rd_data;
  logic [MAX_POSITIONS_LOG2-1:0] ram_wr_addr;
  logic                          ram_full;
  logic                          sort_busy;
  logic                          sort_complete;
  logic [MAX_POSITIONS_LOG2-1:0] pass_count;

  modport master (
    output sort_start, sort_clear, white_to_move, top_k,
    output ram_wr_addr_init, ram_wr, ram_wr_data, ram_rd_addr,
    input  ram_rd_data, ram_wr_addr, ram_full, sort_busy, sort_complete, pass_count
  );

  modport slave (
    input  sort_start, sort_clear, white_to_move, top_k,
    input  ram_wr_addr_init, ram_wr, ram_wr_data, ram_rd_addr,
    output ram_rd_data, ram_wr_addr, ram_full, sort_busy, sort_complete, pass_count
  );
endinterface
`default_nettype wire

// File: rtl/move_sort_topk_mram.sv
// move_sort_topk_mram -- true dual-port RAM, registered 1-cycle read, independent write per port.
// Rev 1.0
`default_nettype none
module move_sort_topk_mram
  import move_sort_topk_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = MAX_POSITIONS_LOG2_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  i_we_a,
  input  wire logic [DEPTH_LOG2-1:0] i_addr_a,
  input  wire logic [WIDTH-1:0]      i_wdata_a,
  output logic      [WIDTH-1:0]      o_rdata_a,
  input  wire logic                  i_we_b,
  input  wire logic [DEPTH_LOG2-1:0] i_addr_b,
  input  wire logic [WIDTH-1:0]      i_wdata_b,
  output logic      [WIDTH-1:0]      o_rdata_b
);
  logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;

  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    r_rdata_a <= r_mem[i_addr_a];
    r_rdata_b <= r_mem[i_addr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
endmodule
`default_nettype wire

// File: rtl/move_sort_topk.sv
// move_sort_topk -- in-place stable bubble sort of an evaluated move list, optionally top-k only.
// Rev 1.0
`default_nettype none
module move_sort_topk
  import move_sort_topk_pkg::*;
#(
  parameter int RAM_WIDTH          = 64,
  parameter int EVAL_WIDTH         = 32,
  parameter int MAX_POSITIONS_LOG2 = MAX_POSITIONS_LOG2_DEF
) (
  input wire logic         clk,
  input wire logic         reset,
  move_sort_topk_if.slave  io
);
  localparam int L = MAX_POSITIONS_LOG2;
  localparam logic [L-1:0] ADDR_MAX = '1;

  sort_state_t         r_state;
  logic [L-1:0]        r_n, r_limit, r_p, r_a, r_b, r_wr_addr, r_pass_count;
  logic                r_swapped, r_wtm, r_start_d1, r_start_d2, r_busy, r_complete;
  logic [RAM_WIDTH-1:0] w_rd_a, w_rd_b, w_wdata_a, w_wdata_b;
  logic [L-1:0]        w_addr_a, w_addr_b, w_limit;
  logic                w_we_a, w_we_b, w_host, w_full, w_host_wr, w_start, w_b_better;

  function automatic logic better(input logic [EVAL_WIDTH+1:0] x, input logic [EVAL_WIDTH+1:0] y,
                                  input logic wtm);
    logic signed [EVAL_WIDTH-1:0] ex, ey;
    logic fx, fy;
    ex = x[EVAL_WIDTH-1:0];
    ey = y[EVAL_WIDTH-1:0];
    fx = wtm ? x[EVAL_WIDTH+BLACK_IN_CHECK_OFS] : x[EVAL_WIDTH+WHITE_IN_CHECK_OFS];
    fy = wtm ? y[EVAL_WIDTH+BLACK_IN_CHECK_OFS] : y[EVAL_WIDTH+WHITE_IN_CHECK_OFS];
    if (ex != ey) return wtm ? (ex > ey) : (ex < ey);
    return fx & ~fy;
  endfunction

  assign w_host     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_full     = (r_wr_addr == ADDR_MAX);
  assign w_host_wr  = w_host & io.ram_wr & (io.ram_wr_addr_init | ~w_full);
  assign w_start    = r_start_d1 & ~r_start_d2;
  assign w_limit    = ((io.top_k == '0) || (io.top_k > r_wr_addr - L'(1))) ? r_wr_addr - L'(1) : io.top_k;
  assign w_b_better = better(w_rd_b[EVAL_WIDTH+1:0], w_rd_a[EVAL_WIDTH+1:0], r_wtm);

  // Host owns port A (write) and port B (read) outside a sort; the sorter owns both during one.
  always_comb begin
    w_addr_a  = r_a;
    w_addr_b  = r_b;
    w_we_a    = 1'b0;
    w_we_b    = 1'b0;
    w_wdata_a = w_rd_b;
    w_wdata_b = w_rd_a;
    if (w_host) begin
      w_addr_a  = io.ram_wr_addr_init ? '0 : r_wr_addr;
      w_addr_b  = io.ram_rd_addr;
      w_we_a    = w_host_wr & ~reset;
      w_wdata_a = io.ram_wr_data;
    end else if (r_state == S_SWAP) begin
      w_we_a = ~reset;
      w_we_b = ~reset;
    end
  end

  move_sort_topk_mram #(.WIDTH(RAM_WIDTH), .DEPTH_LOG2(L)) u_mram (
    .clk      (clk),
    .i_we_a   (w_we_a),
    .i_addr_a (w_addr_a),
    .i_wdata_a(w_wdata_a),
    .o_rdata_a(w_rd_a),
    .i_we_b   (w_we_b),
    .i_addr_b (w_addr_b),
    .i_wdata_b(w_wdata_b),
    .o_rdata_b(w_rd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_addr    <= '0;
      r_pass_count <= '0;
      r_busy       <= 1'b0;
      r_complete   <= 1'b0;
      r_start_d1   <= 1'b0;
      r_start_d2   <= 1'b0;
      r_swapped    <= 1'b0;
      r_wtm        <= 1'b0;
      r_n          <= '0;
      r_limit      <= '0;
      r_p          <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else begin
      r_start_d1 <= io.sort_start;
      r_start_d2 <= r_start_d1;
      if (w_host) begin
        if (io.ram_wr_addr_init) r_wr_addr <= {{(L-1){1'b0}}, io.ram_wr};
        else if (w_host_wr)      r_wr_addr <= r_wr_addr + L'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_n          <= r_wr_addr;
            r_limit      <= w_limit;
            r_wtm        <= io.white_to_move;
            r_p          <= '0;
            r_pass_count <= '0;
            if (r_wr_addr <= L'(1)) begin
              r_state    <= S_DONE;
              r_complete <= 1'b1;
            end else begin
              r_state <= S_PASS_INIT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (io.sort_clear) begin
            r_state    <= S_IDLE;
            r_complete <= 1'b0;
          end
        end
        default: begin
          if (io.sort_clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            case (r_state)
              S_PASS_INIT: begin
                r_a       <= r_n - L'(2);
                r_b       <= r_n - L'(1);
                r_swapped <= 1'b0;
                r_state   <= S_READ_WS;
              end
              S_READ_WS: r_state <= S_COMPARE;
              S_COMPARE: r_state <= w_b_better ? S_SWAP : S_STEP;
              S_SWAP: begin
                r_swapped <= 1'b1;
                r_state   <= S_STEP;
              end
              S_STEP: begin
                if (r_a == r_p) begin
                  r_state <= S_PASS_CHECK;
                end else begin
                  r_a     <= r_a - L'(1);
                  r_b     <= r_b - L'(1);
                  r_state <= S_READ_WS;
                end
              end
              S_PASS_CHECK: begin
                r_pass_count <= r_pass_count + L'(1);
                if (!r_swapped || (r_p + L'(1) == r_limit)) begin
                  r_state    <= S_DONE;
                  r_busy     <= 1'b0;
                  r_complete <= 1'b1;
                end else begin
                  r_p     <= r_p + L'(1);
                  r_state <= S_PASS_INIT;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign io.ram_rd_data   = w_rd_b;
  assign io.ram_wr_addr   = r_wr_addr;
  assign io.ram_full      = w_full;
  assign io.sort_busy     = r_busy;
  assign io.sort_complete = r_complete;
  assign io.pass_count    = r_pass_count;
endmodule
`default_nettype wire

// File: tb/tb_move_sort_topk.sv
// tb_move_sort_topk -- scoreboard bench: stimulus queues expected values, monitors pop and compare.
`default_nettype none
`timescale 1ns/1ps
module tb_move_sort_topk;
  import move_sort_topk_pkg::*;
  localparam int W  = 64;
  localparam int EW = 32;
  localparam int L  = 8;

  typedef enum int {K_BUSY, K_COMPLETE, K_PASS, K_PASS_LE, K_WADDR, K_FULL} kind_t;
  typedef struct { kind_t kind; logic [63:0] exp; string name; } st_item_t;
  typedef struct { logic [63:0] exp; string name; } rd_item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_sort_topk_if #(.RAM_WIDTH(W), .MAX_POSITIONS_LOG2(L)) bus();
  move_sort_topk #(.RAM_WIDTH(W), .EVAL_WIDTH(EW), .MAX_POSITIONS_LOG2(L)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  st_item_t    st_q[$];
  rd_item_t    rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  event        st_ev;
  logic        rd_req = 1'b0;
  logic        rd_pending = 1'b0;
  logic [63:0] vec[$];
  logic [63:0] expv[$];

  function automatic logic [63:0] mk(input int ev, input bit bchk, input bit wchk);
    mk = {30'b0, wchk, bchk, ev[31:0]};
  endfunction

  // Status monitor: compares whenever stimulus announces a status expectation.
  always begin
    @(st_ev);
    while (st_q.size() > 0) begin
      st_item_t    it;
      logic [63:0] act;
      bit          ok;
      it  = st_q.pop_front();
      act = '0;
      case (it.kind)
        K_BUSY:     act = 64'(bus.sort_busy);
        K_COMPLETE: act = 64'(bus.sort_complete);
        K_PASS:     act = 64'(bus.pass_count);
        K_PASS_LE:  act = 64'(bus.pass_count);
        K_WADDR:    act = 64'(bus.ram_wr_addr);
        K_FULL:     act = 64'(bus.ram_full);
        default:    act = '1;
      endcase
      ok = (it.kind == K_PASS_LE) ? (act <= it.exp) : (act == it.exp);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got %0d, required %s%0d", it.name, act,
                 (it.kind == K_PASS_LE) ? "<= " : "", it.exp);
      end
    end
  end

  // Read monitor: data is valid one cycle after the address was presented.
  always @(posedge clk) rd_pending <= rd_req;
  always @(negedge clk) begin
    if (rd_pending) begin
      rd_item_t it;
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: got data %0h, required no read", bus.ram_rd_data);
      end else begin
        it = rd_q.pop_front();
        if (bus.ram_rd_data !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, required %0h", it.name, bus.ram_rd_data, it.exp);
        end
      end
    end
  end

  task automatic probe(input kind_t k, input logic [63:0] e, input string nm);
    st_item_t it;
    it.kind = k; it.exp = e; it.name = nm;
    st_q.push_back(it);
    -> st_ev;
    #1;
  endtask

  task automatic rd(input logic [L-1:0] a, input logic [63:0] e, input string nm);
    rd_item_t it;
    it.exp = e; it.name = nm;
    @(negedge clk);
    bus.ram_rd_addr = a;
    rd_req = 1'b1;
    rd_q.push_back(it);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [63:0] d, input logic init);
    @(negedge clk);
    bus.ram_wr = 1'b1; bus.ram_wr_addr_init = init; bus.ram_wr_data = d;
    @(negedge clk);
    bus.ram_wr = 1'b0; bus.ram_wr_addr_init = 1'b0;
  endtask

  task automatic load();
    foreach (vec[i]) wr(vec[i], i == 0);
  endtask

  task automatic check_all(input string nm);
    foreach (expv[i]) rd(L'(i), expv[i], $sformatf("%s[%0d]", nm, i));
  endtask

  task automatic start_pulse(input logic wtm, input logic [L-1:0] k);
    @(negedge clk);
    bus.white_to_move = wtm; bus.top_k = k; bus.sort_start = 1'b1;
    @(negedge clk);
    bus.sort_start = 1'b0;
  endtask

  task automatic start_wait(input logic wtm, input logic [L-1:0] k, input int budget, input string nm);
    int c;
    start_pulse(wtm, k);
    c = 1;
    while (!bus.sort_complete && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!bus.sort_complete) begin
      n_fail++;
      $display("FAIL %s: sort_complete=0 after %0d cycles, required 1", nm, c);
    end
  endtask

  // Checks sort_complete rises exactly cyc clock edges after sort_start is raised.
  task automatic start_exact(input logic wtm, input logic [L-1:0] k, input int cyc, input string nm);
    @(negedge clk);
    bus.white_to_move = wtm; bus.top_k = k; bus.sort_start = 1'b1;
    for (int i = 1; i < cyc; i++) begin
      @(negedge clk);
      if (i == 1) bus.sort_start = 1'b0;
    end
    probe(K_COMPLETE, 0, {nm, "_early"});
    @(negedge clk);
    probe(K_COMPLETE, 1, {nm, "_ontime"});
  endtask

  task automatic clear();
    @(negedge clk); bus.sort_clear = 1'b1;
    @(negedge clk); bus.sort_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.sort_start = 1'b0; bus.sort_clear = 1'b0; bus.white_to_move = 1'b0; bus.top_k = '0;
    bus.ram_wr_addr_init = 1'b0; bus.ram_wr = 1'b0; bus.ram_wr_data = '0; bus.ram_rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    probe(K_BUSY, 0, "rst_busy");
    probe(K_COMPLETE, 0, "rst_complete");
    probe(K_PASS, 0, "rst_pass_count");
    probe(K_WADDR, 0, "rst_wr_addr");
    probe(K_FULL, 0, "rst_full");

    vec = '{mk(5,0,0), mk(-3,0,0), mk(9,0,0), mk(0,0,0)};
    load();
    probe(K_WADDR, 4, "load4_wr_addr");
    start_wait(1'b1, 0, 300, "white4_done");
    expv = '{mk(9,0,0), mk(5,0,0), mk(0,0,0), mk(-3,0,0)};
    check_all("white4");
    clear();
    probe(K_COMPLETE, 0, "clear_to_idle");
    start_wait(1'b0, 0, 300, "black4_done");
    expv = '{mk(-3,0,0), mk(0,0,0), mk(5,0,0), mk(9,0,0)};
    check_all("black4");
    clear();

    vec = '{mk(7,0,0), mk(7,1,0)};
    load();
    start_exact(1'b1, 0, 8, "tie_swap_latency");
    expv = '{mk(7,1,0), mk(7,0,0)};
    check_all("tie_bchk_first");
    clear();
    vec = '{mk(7,0,1), mk(7,0,0)};
    load();
    start_exact(1'b1, 0, 7, "tie_keep_latency");
    expv = vec;
    check_all("tie_stable");
    clear();
    vec = '{mk(7,1,0), mk(7,0,1)};
    load();
    start_wait(1'b0, 0, 100, "black_tie_done");
    expv = '{mk(7,0,1), mk(7,1,0)};
    check_all("black_tie_wchk_first");
    clear();

    vec = '{mk(12,0,0), mk(-7,0,0), mk(33,0,0), mk(4,0,0), mk(0,0,0), mk(25,0,0), mk(-18,0,0), mk(9,0,0),
            mk(41,0,0), mk(-2,0,0), mk(17,0,0), mk(6,0,0), mk(-30,0,0), mk(28,0,0), mk(3,0,0), mk(15,0,0)};
    load();
    start_wait(1'b1, 3, 3000, "topk3_done");
    probe(K_PASS_LE, 3, "topk3_pass_count");
    expv = '{mk(41,0,0), mk(33,0,0), mk(28,0,0)};
    check_all("topk3_best");
    clear();
    start_wait(1'b1, 0, 5000, "full16_done");
    expv = '{mk(41,0,0), mk(33,0,0), mk(28,0,0), mk(25,0,0), mk(17,0,0), mk(15,0,0), mk(12,0,0), mk(9,0,0),
             mk(6,0,0), mk(4,0,0), mk(3,0,0), mk(0,0,0), mk(-2,0,0), mk(-7,0,0), mk(-18,0,0), mk(-30,0,0)};
    check_all("full16_multiset");
    clear();

    vec = '{mk(8,0,0), mk(7,0,0), mk(6,0,0), mk(5,0,0), mk(4,0,0), mk(3,0,0), mk(2,0,0), mk(1,0,0)};
    load();
    start_wait(1'b1, 0, 500, "sorted8_done");
    probe(K_PASS, 1, "sorted8_pass_count");
    expv = vec;
    check_all("sorted8");
    clear();
    vec = '{mk(3,0,0)};
    load();
    start_exact(1'b1, 0, 2, "single_latency");
    probe(K_PASS, 0, "single_pass_count");
    clear();

    vec = '{mk(1,0,0), mk(2,0,0), mk(3,0,0), mk(4,0,0), mk(5,0,0), mk(6,0,0), mk(7,0,0), mk(8,0,0)};
    load();
    start_pulse(1'b1, 0);
    repeat (8) @(negedge clk);
    probe(K_BUSY, 1, "midsort_busy");
    wr(mk(99,0,0), 1'b1);
    probe(K_WADDR, 8, "busy_write_ignored");
    @(negedge clk); bus.sort_clear = 1'b1;
    @(negedge clk); bus.sort_clear = 1'b0;
    probe(K_BUSY, 0, "abort_busy_next_cycle");
    probe(K_COMPLETE, 0, "abort_complete");
    probe(K_WADDR, 8, "abort_wr_addr_kept");
    start_wait(1'b1, 0, 1000, "resort_done");
    expv = '{mk(8,0,0), mk(7,0,0), mk(6,0,0), mk(5,0,0), mk(4,0,0), mk(3,0,0), mk(2,0,0), mk(1,0,0)};
    check_all("resort");
    clear();

    vec = '{mk(1,0,0), mk(2,0,0), mk(3,0,0), mk(4,0,0)};
    load();
    start_pulse(1'b1, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    probe(K_BUSY, 0, "midsort_reset_busy");
    probe(K_WADDR, 0, "midsort_reset_wr_addr");
    probe(K_PASS, 0, "midsort_reset_pass_count");

    @(negedge clk);
    bus.ram_wr_addr_init = 1'b1; bus.ram_wr = 1'b1; bus.ram_wr_data = 64'd0;
    for (int i = 1; i < 255; i++) begin
      @(negedge clk);
      bus.ram_wr_addr_init = 1'b0; bus.ram_wr_data = 64'(i);
    end
    @(negedge clk);
    bus.ram_wr = 1'b0;
    probe(K_FULL, 1, "full_flag");
    probe(K_WADDR, 255, "full_wr_addr");
    wr(mk(77,0,0), 1'b0);
    probe(K_WADDR, 255, "write_at_full_ignored");
    probe(K_FULL, 1, "full_flag_held");
    rd(8'd254, 64'd254, "full_last_entry");
    wr(mk(5,0,0), 1'b1);
    probe(K_WADDR, 1, "init_with_write_addr");
    probe(K_FULL, 0, "init_clears_full");
    rd(8'd0, mk(5,0,0), "init_with_write_data");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/move_sort_topk.md
MOVE_SORT_TOPK -- requirements
Module: move_sort_topk

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 64: entry width in bits.
REQ-002 SHALL have parameter EVAL_WIDTH, default 32: signed eval field width in entry[EVAL_WIDTH-1:0]. Black-in-check flag is entry[EVAL_WIDTH]; white-in-check flag is entry[EVAL_WIDTH+1].
REQ-003 SHALL have parameter MAX_POSITIONS_LOG2, default 8: RAM depth is 2^MAX_POSITIONS_LOG2.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 sync active-high reset.
REQ-005 SHALL have ports: sort_start in 1 (rising edge starts a sort); sort_clear in 1 (acknowledge or abort); white_to_move in 1 (ordering mode); top_k in MAX_POSITIONS_LOG2 (number of leading entries to finalise, 0 = full sort).
REQ-006 SHALL have ports: ram_wr_addr_init in 1; ram_wr in 1; ram_wr_data in RAM_WIDTH; ram_rd_addr in MAX_POSITIONS_LOG2.
REQ-007 SHALL have ports: ram_rd_data out RAM_WIDTH; ram_wr_addr out MAX_POSITIONS_LOG2 (entry count); ram_full out 1; sort_busy out 1; sort_complete out 1; pass_count out MAX_POSITIONS_LOG2.

Function
REQ-008 SHALL rank entry X better than entry Y when white_to_move is 1 and (evalX > evalY, or evals are equal with X black-in-check = 1 and Y black-in-check = 0).
REQ-009 SHALL rank entry X better than entry Y when white_to_move is 0 and (evalX < evalY, or evals are equal with X white-in-check = 1 and Y white-in-check = 0); white_to_move SHALL be registered at sort start.
REQ-010 SHALL give external IO exclusive RAM access in IDLE and DONE: ram_wr writes ram_wr_data at ram_wr_addr and then increments it; ram_rd_data returns RAM[ram_rd_addr] one cycle after the address.
REQ-011 SHALL clear ram_wr_addr to 0 on ram_wr_addr_init; if ram_wr_addr_init and ram_wr occur in the same cycle, the data SHALL be written at address 0 and ram_wr_addr SHALL become 1.
REQ-012 SHALL assert ram_full when ram_wr_addr = 2^MAX_POSITIONS_LOG2-1, and SHALL drop further ram_wr while ram_full is 1 (no write, no wrap).
REQ-013 SHALL ignore ram_wr and ram_wr_addr_init while sort_busy is 1.
REQ-014 SHALL implement states IDLE, PASS_INIT, READ_WS, COMPARE, SWAP, STEP, PASS_CHECK, DONE.
REQ-015 SHALL, in IDLE, on a sort_start rising edge latch n = ram_wr_addr and limit = (top_k == 0 or top_k > n-1) ? n-1 : top_k; the next state SHALL be DONE if n <= 1, else PASS_INIT with p = 0.
REQ-016 SHALL, in PASS_INIT, set a = n-2 and b = n-1 and clear the swapped flag.
REQ-017 SHALL spend one cycle in READ_WS for the 1-cycle RAM read latency, then go to COMPARE.
REQ-018 SHALL, in COMPARE, go to SWAP if RAM[b] is better than RAM[a], else to STEP.
REQ-019 SHALL, in SWAP, write RAM[a] <= old RAM[b] and RAM[b] <= old RAM[a] simultaneously on ports A and B, and set the swapped flag.
REQ-020 SHALL, in STEP, go to PASS_CHECK if a == p, else decrement a and b and go to READ_WS.
REQ-021 SHALL, in PASS_CHECK, increment pass_count and go to DONE if the swapped flag is 0 or p+1 == limit; otherwise it SHALL increment p and go to PASS_INIT.
REQ-022 SHALL guarantee that after DONE, RAM[0..limit-1] holds the limit best entries in rank order, with equal-rank entries keeping their original relative order (stable sort).
REQ-023 SHALL hold sort_busy = 1 in every state except IDLE and DONE, and sort_complete = 1 only in DONE.
REQ-024 SHALL, in DONE, go to IDLE on sort_clear; sort_clear during a sort SHALL abort the sort to IDLE within one cycle, leaving RAM partially sorted and ram_wr_addr unchanged.
REQ-025 SHALL clear pass_count at each sort start.
REQ-026 SHALL take 3 cycles per non-swapping compare and 4 cycles per swapping compare.

Reset
REQ-027 SHALL, on reset, set the state to IDLE, ram_wr_addr = 0, ram_full = 0, sort_busy = 0, sort_complete = 0, pass_count = 0, and deassert all RAM write enables.
REQ-028 SHALL accept reset mid-sort with the same result as REQ-027; RAM contents are undefined after it.

Structure
REQ-029 SHALL place the state encodings and the entry flag bit offsets in the shared vchess package/header, alongside MAX_POSITIONS.
REQ-030 SHALL instantiate the existing dual-port BRAM sub-module mram (1-cycle read, independent write per port) and SHALL NOT require same-address read-during-write behaviour.

Verification
REQ-031 SHALL cover: white, top_k = 0, evals written in order 5, -3, 9, 0 -> read back 9, 5, 0, -3.
REQ-032 SHALL cover: black, same four entries -> read back -3, 0, 5, 9.
REQ-033 SHALL cover: white, two entries with eval 7, second entry black-in-check -> entry with black-in-check at index 0; with both flags equal, original order kept.
REQ-034 SHALL cover: 16 random entries, top_k = 3 -> indices 0..2 hold the 3 best; pass_count <= 3; the multiset of all 16 entries is preserved.
REQ-035 SHALL cover: entries already sorted (8 entries) -> DONE after 1 pass with pass_count = 1; a single entry -> sort_complete 2 cycles after start.
REQ-036 SHALL cover: sort_clear asserted mid-sort -> sort_busy = 0 the next cycle; a new sort then completes correctly; a write at ram_full -> ignored.
